// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter: FSM states and the
// read-return tag carried down the fixed-latency pipeline.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam int TAG_DEPTH = 2;
    localparam int CNT_W     = 8;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (CPU = 0, monitor/loader = 1) with lock,
// burst-limited rotation and a fixed two-edge read return path.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int addr_width = 9,
    parameter int max_burst  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_we,
    input  logic [addr_width-1:0] m0_addr,
    input  logic [7:0]            m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_we,
    input  logic [addr_width-1:0] m1_addr,
    input  logic [7:0]            m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [7:0]            rdata,
    output logic [addr_width-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_write,
    input  logic [7:0]            mem_rdata
);

    localparam logic [CNT_W-1:0] MAX_BURST = CNT_W'(max_burst);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [CNT_W-1:0]      r_burst_cnt;
    logic                  r_last_owner;
    logic [addr_width-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;
    logic                  r_mem_write;
    rd_tag_t               r_tag [TAG_DEPTH];
    logic                  r_m0_rvalid;
    logic                  r_m1_rvalid;
    logic [7:0]            r_rdata;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_acc;
    logic                  w_acc_we;
    logic [addr_width-1:0] w_acc_addr;
    logic [7:0]            w_acc_wdata;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_burst_done;
    logic                  w_exit;

    assign w_gnt0 = (r_state == ST_OWN0) & m0_req;
    assign w_gnt1 = (r_state == ST_OWN1) & m1_req;
    assign w_acc  = w_gnt0 | w_gnt1;

    assign w_acc_we    = w_gnt1 ? m1_we    : m0_we;
    assign w_acc_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_acc_wdata = w_gnt1 ? m1_wdata : m0_wdata;

    assign w_cnt_inc = (r_burst_cnt == MAX_BURST) ? r_burst_cnt : r_burst_cnt + 1'b1;

    // The limit counts the access accepted on this edge, so rotation lands
    // right after the max_burst-th access rather than one later.
    assign w_burst_done = ((w_acc ? w_cnt_inc : r_burst_cnt) == MAX_BURST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_req && m1_req)
                    w_state_next = r_last_owner ? ST_OWN0 : ST_OWN1;
                else if (m0_req)
                    w_state_next = ST_OWN0;
                else if (m1_req)
                    w_state_next = ST_OWN1;
            end
            ST_OWN0: begin
                if (!m0_lock && (!m0_req || (w_burst_done && m1_req)))
                    w_state_next = ST_IDLE;
            end
            ST_OWN1: begin
                if (!m1_lock && (!m1_req || (w_burst_done && m0_req)))
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_exit = (r_state != ST_IDLE) && (w_state_next == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_burst_cnt  <= '0;
            r_last_owner <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_exit) begin
                r_burst_cnt  <= '0;
                r_last_owner <= (r_state == ST_OWN1);
            end else if (w_acc) begin
                r_burst_cnt <= w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= 1'b0;
        end else begin
            r_mem_write <= w_acc & w_acc_we;
            if (w_acc) begin
                r_mem_addr  <= w_acc_addr;
                r_mem_wdata <= w_acc_wdata;
            end
        end
    end

    // Tags follow each read so the byte returns to its issuer even after
    // ownership has moved on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAG_DEPTH; i++)
                r_tag[i] <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_tag[0].valid <= w_acc & ~w_acc_we;
            r_tag[0].owner <= w_gnt1;
            for (int i = 1; i < TAG_DEPTH; i++)
                r_tag[i] <= r_tag[i-1];
            r_m0_rvalid <= r_tag[TAG_DEPTH-1].valid & ~r_tag[TAG_DEPTH-1].owner;
            r_m1_rvalid <= r_tag[TAG_DEPTH-1].valid &  r_tag[TAG_DEPTH-1].owner;
            if (r_tag[TAG_DEPTH-1].valid)
                r_rdata <= mem_rdata;
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a synchronous memory model, a read
// scoreboard keyed by requester, and one task per scenario.
module tb_mem_arbiter;

    localparam int AW = 9;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [7:0]    m0_wdata = '0;
    logic          m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [7:0]    m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write;
    logic [7:0]    rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = '0;

    mem_arbiter #(.addr_width(AW), .max_burst(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] preload(input logic [AW-1:0] a);
        if (a == 9'h010) return 8'hA5;
        return a[7:0] ^ 8'h5A ^ {7'd0, a[8]};
    endfunction

    // Memory: data valid one edge after mem_addr changes.
    bit [7:0] mem    [512];
    bit       mem_wr [512];
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr]    <= mem_wdata;
            mem_wr[mem_addr] <= 1'b1;
        end
        mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : preload(mem_addr);
    end

    bit [7:0]   shadow    [512];
    bit         shadow_wr [512];
    logic [7:0] exp_q0[$], exp_q1[$];
    int         due_q0[$], due_q1[$];

    int n_pass = 0, n_total = 0, cycle = 0;
    int n_acc0 = 0, n_acc1 = 0, n_wr_pulse = 0, n_rv = 0;
    logic s_gnt0, s_gnt1, s_acc0, s_acc1, s_mem_write;
    logic [AW-1:0] s_mem_addr;
    logic [7:0] s_mem_wdata, last_rd0;

    task automatic sample();
        logic [7:0] e;
        int d;
        s_gnt0 = m0_gnt;
        s_gnt1 = m1_gnt;
        s_acc0 = m0_req & m0_gnt;
        s_acc1 = m1_req & m1_gnt;
        s_mem_write = mem_write;
        s_mem_addr  = mem_addr;
        s_mem_wdata = mem_wdata;
        if (mem_write) n_wr_pulse++;
        if (s_acc0) begin
            n_acc0++;
            if (m0_we) begin
                shadow[m0_addr] = m0_wdata; shadow_wr[m0_addr] = 1'b1;
            end else begin
                exp_q0.push_back(shadow_wr[m0_addr] ? shadow[m0_addr] : preload(m0_addr));
                due_q0.push_back(cycle + 3);
            end
        end
        if (s_acc1) begin
            n_acc1++;
            if (m1_we) begin
                shadow[m1_addr] = m1_wdata; shadow_wr[m1_addr] = 1'b1;
            end else begin
                exp_q1.push_back(shadow_wr[m1_addr] ? shadow[m1_addr] : preload(m1_addr));
                due_q1.push_back(cycle + 3);
            end
        end
        if (m0_rvalid) begin
            n_rv++; n_total++; last_rd0 = rdata;
            if (exp_q0.size() == 0) begin
                $display("FAIL rvalid0_unexpected: rdata=%0h at cycle %0d, no read pending", rdata, cycle);
            end else begin
                e = exp_q0.pop_front(); d = due_q0.pop_front();
                if (rdata !== e || cycle != d)
                    $display("FAIL rvalid0_data: got %0h at cycle %0d, expected %0h at cycle %0d", rdata, cycle, e, d);
                else n_pass++;
            end
        end
        if (m1_rvalid) begin
            n_rv++; n_total++;
            if (exp_q1.size() == 0) begin
                $display("FAIL rvalid1_unexpected: rdata=%0h at cycle %0d, no read pending", rdata, cycle);
            end else begin
                e = exp_q1.pop_front(); d = due_q1.pop_front();
                if (rdata !== e || cycle != d)
                    $display("FAIL rvalid1_data: got %0h at cycle %0d, expected %0h at cycle %0d", rdata, cycle, e, d);
                else n_pass++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 0;
        m1_req = 0; m1_lock = 0; m1_we = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 1; m1_req = 1;
        tick(); tick();
        n_total++;
        if ({m0_gnt, m1_gnt} !== 2'b00)
            $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
        else n_pass++;
        n_total++;
        if ({m0_rvalid, m1_rvalid, mem_write} !== 3'b000)
            $display("FAIL reset_pulses: got %b expected 000", {m0_rvalid, m1_rvalid, mem_write});
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata, rdata} !== '0)
            $display("FAIL reset_data: got addr=%0h wdata=%0h rdata=%0h expected 0", mem_addr, mem_wdata, rdata);
        else n_pass++;
        clear_inputs();
        reset = 1'b0;
        $display("reset: outputs checked while reset high");
    endtask

    task automatic test_single_read();
        int rv0;
        do_reset();
        rv0 = n_rv;
        m0_req = 1; m0_we = 0; m0_addr = 9'h010;
        tick();
        n_total++;
        if (s_gnt0 !== 1'b0) $display("FAIL idle_no_gnt: got %b expected 0", s_gnt0);
        else n_pass++;
        tick();
        n_total++;
        if (s_acc0 !== 1'b1) $display("FAIL own0_gnt: got %b expected 1", s_acc0);
        else n_pass++;
        m0_req = 0;
        drain();
        n_total++;
        if (n_rv - rv0 != 1 || last_rd0 !== 8'hA5)
            $display("FAIL single_read: got %0d pulses data %0h expected 1 pulse data a5", n_rv - rv0, last_rd0);
        else n_pass++;
        $display("single_read: m0 read 0x010 -> %0h", last_rd0);
    endtask

    task automatic test_tie();
        int k;
        do_reset();
        m0_req = 1; m0_addr = 9'h011;
        m1_req = 1; m1_addr = 9'h111;
        tick(); tick();
        n_total++;
        if (s_acc0 !== 1'b1 || s_gnt1 !== 1'b0)
            $display("FAIL tie_m0_first: got acc0=%b gnt1=%b expected 1 0", s_acc0, s_gnt1);
        else n_pass++;
        m0_req = 0;
        k = 0;
        do begin tick(); k++; end while (!s_acc1 && k < 10);
        n_total++;
        if (k != 3 || !s_acc1) $display("FAIL tie_m1_after_idle: got %0d cycles expected 3", k);
        else n_pass++;
        m1_req = 0;
        drain();
        $display("tie: m0 first, m1 accepted %0d cycles after release", k);
    endtask

    task automatic test_lock();
        int k, bad, a1, a0;
        do_reset();
        a1 = n_acc1;
        m1_req = 1; m1_lock = 1; m1_addr = 9'h100;
        k = 0;
        do begin tick(); k++; end while (!s_acc1 && k < 10);
        m0_req = 1; m0_addr = 9'h000;
        a0 = n_acc0;
        bad = 0;
        for (int i = 1; i < 12; i++) begin
            m1_addr = 9'h100 + AW'(i);
            tick();
            if (!s_acc1 || s_gnt0) bad++;
        end
        n_total++;
        if (bad != 0 || n_acc1 - a1 != 12 || n_acc0 != a0)
            $display("FAIL lock_b2b: got %0d m1 accepts, %0d gaps, %0d m0 accepts expected 12 0 0", n_acc1 - a1, bad, n_acc0 - a0);
        else n_pass++;
        m1_req = 0; m1_lock = 0;
        k = 0;
        do begin tick(); k++; end while (!s_acc0 && k < 10);
        n_total++;
        if (k != 3 || !s_acc0) $display("FAIL lock_release_m0: got %0d cycles expected 3", k);
        else n_pass++;
        m0_req = 0;
        drain();
        $display("lock: m1 served %0d reads, m0 granted %0d cycles after unlock", n_acc1 - a1, k);
    endtask

    task automatic test_burst();
        int k, c0;
        do_reset();
        m0_req = 1; m0_addr = 9'h040;
        k = 0;
        do begin tick(); k++; end while (!s_acc0 && k < 10);
        m1_req = 1; m1_addr = 9'h140;
        c0 = 1;
        k = 0;
        do begin
            m0_addr = m0_addr + 1'b1;
            tick(); k++;
            if (s_acc0) c0++;
        end while (!s_acc1 && k < 40);
        n_total++;
        if (!s_acc1) $display("FAIL burst_m1_served: got no m1 accept in %0d cycles expected accept", k);
        else n_pass++;
        n_total++;
        if (c0 != 8) $display("FAIL burst_m0_count: got %0d expected 8", c0);
        else n_pass++;
        m0_req = 0; m1_req = 0;
        drain();
        $display("burst: m0 accepted %0d before rotation", c0);
    endtask

    task automatic test_write_read();
        int k, wp0;
        wp0 = n_wr_pulse;
        m0_req = 1; m0_we = 1; m0_addr = 9'h020; m0_wdata = 8'h3C;
        k = 0;
        do begin tick(); k++; end while (!s_acc0 && k < 10);
        m0_we = 0;
        tick();
        n_total++;
        if (s_mem_write !== 1'b1 || s_mem_addr !== 9'h020 || s_mem_wdata !== 8'h3C || !s_acc0)
            $display("FAIL wr_mem_outputs: got we=%b addr=%0h wdata=%0h acc=%b expected 1 20 3c 1", s_mem_write, s_mem_addr, s_mem_wdata, s_acc0);
        else n_pass++;
        m0_req = 0;
        drain();
        n_total++;
        if (n_wr_pulse - wp0 != 1) $display("FAIL wr_single_pulse: got %0d expected 1", n_wr_pulse - wp0);
        else n_pass++;
        n_total++;
        if (last_rd0 !== 8'h3C) $display("FAIL wr_rd_data: got %0h expected 3c", last_rd0);
        else n_pass++;
        $display("write_read: 0x020 <- 3c, read back %0h", last_rd0);
    endtask

    task automatic test_reset_mid();
        int k, rv0;
        m0_req = 1; m0_we = 0; m0_addr = 9'h030;
        k = 0;
        do begin tick(); k++; end while (!s_acc0 && k < 10);
        m0_addr = 9'h031;
        tick();
        n_total++;
        if (!s_acc0) $display("FAIL mid_second_accept: got %b expected 1", s_acc0);
        else n_pass++;
        #1;
        reset = 1'b1;
        #1;
        n_total++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write, mem_addr, mem_wdata, rdata} !== '0)
            $display("FAIL mid_reset_outputs: got gnt=%b%b rv=%b%b we=%b addr=%0h rdata=%0h expected all 0",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write, mem_addr, rdata);
        else n_pass++;
        exp_q0.delete(); due_q0.delete();
        exp_q1.delete(); due_q1.delete();
        clear_inputs();
        tick(); tick();
        reset = 1'b0;
        rv0 = n_rv;
        repeat (6) tick();
        n_total++;
        if (n_rv != rv0) $display("FAIL no_rvalid_after_reset: got %0d pulses expected 0", n_rv - rv0);
        else n_pass++;
        $display("reset_mid: reset with two reads in flight");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_lock();
        test_burst();
        test_write_read();
        test_reset_mid();
        n_total++;
        if (exp_q0.size() + exp_q1.size() != 0)
            $display("FAIL scoreboard_drained: got %0d pending reads expected 0", exp_q0.size() + exp_q1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
